// File: rtl/rf_pkg.sv
// ============================================================================
//  Module : rf_pkg
//  Shared constants and address-decode helper for the multi-port register file.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int XLEN     = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;

    localparam logic [RF_AW-1:0] ZERO_REG = '0;

    function automatic logic [RF_DEPTH-1:0] onehot_dec(input logic [RF_AW-1:0] addr);
        logic [RF_DEPTH-1:0] v;
        v = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
//  Module : rf_scoreboard
//  Per-register pending-write bits with clear-then-set update and busy lookup.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int DEPTH  = RF_DEPTH,
    parameter  int NUM_WR = 2,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR-1:0]    wr_clr,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 sb_any
);

    logic [DEPTH-1:0] r_sb;
    logic [DEPTH-1:0] w_clr_mask;
    logic [DEPTH-1:0] w_set_mask;

    always_comb begin
        w_clr_mask = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_clr[w]) begin
                w_clr_mask = w_clr_mask | DEPTH'(onehot_dec(RF_AW'(wr_addr[w*AW +: AW])));
            end
        end
    end

    always_comb begin
        w_set_mask = '0;
        if (iss_valid && (iss_rd != AW'(ZERO_REG))) begin
            w_set_mask = DEPTH'(onehot_dec(RF_AW'(iss_rd)));
        end
    end

    // Clear before set: a new producer issued in the retiring cycle keeps the bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sb <= '0;
        end else begin
            r_sb <= ((r_sb & ~w_clr_mask) | w_set_mask) & ~DEPTH'(1);
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
            logic [AW-1:0] w_a;
            assign w_a        = rd_addr[p*AW +: AW];
            assign rd_busy[p] = r_sb[w_a] & ~w_clr_mask[w_a];
        end
    endgenerate

    assign sb_any = |r_sb;

endmodule : rf_scoreboard

`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
// ============================================================================
//  Module : regfile_mp_scoreboard
//  Multi-port register file, x0 hardwired, write-to-read bypass, pending-write scoreboard.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp_scoreboard
    import rf_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int DEPTH  = RF_DEPTH,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_WR-1:0]       wr_clr,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rd,
    output logic                    sb_any
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] w_wr_dec [NUM_WR];

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_dec[w] = '0;
            if (wr_en[w]) begin
                w_wr_dec[w] = DEPTH'(onehot_dec(RF_AW'(wr_addr[w*AW +: AW])));
            end
        end
    end

    // Later ports are assigned last, so the highest index wins an address collision.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                for (int r = 1; r < DEPTH; r++) begin
                    if (w_wr_dec[w][r]) begin
                        r_regs[r] <= wr_data[w*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0]    w_a;
            logic [WIDTH-1:0] w_d;
            assign w_a = rd_addr[p*AW +: AW];

            always_comb begin
                w_d = '0;
                if (w_a != AW'(ZERO_REG)) begin
                    w_d = r_regs[w_a];
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == w_a)) begin
                            w_d = wr_data[w*WIDTH +: WIDTH];
                        end
                    end
                end
            end

            assign rd_data[p*WIDTH +: WIDTH] = w_d;
        end
    endgenerate

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .CLK       (CLK),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .sb_any    (sb_any)
    );

endmodule : regfile_mp_scoreboard

`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
// ============================================================================
//  Module : tb_regfile_mp_scoreboard
//  Directed self-checking bench for the multi-port register file and scoreboard.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp_scoreboard;

    localparam int c_W  = 32;
    localparam int c_AW = 5;

    logic            CLK;
    logic            reset;
    logic [2*c_AW-1:0] rd_addr;
    logic [2*c_W-1:0]  rd_data;
    logic [1:0]      rd_busy;
    logic [1:0]      wr_en;
    logic [2*c_AW-1:0] wr_addr;
    logic [2*c_W-1:0]  wr_data;
    logic [1:0]      wr_clr;
    logic            iss_valid;
    logic [c_AW-1:0] iss_rd;
    logic            sb_any;

    int r_tests;
    int r_fails;

    regfile_mp_scoreboard #(
        .WIDTH  (32),
        .DEPTH  (32),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_clr    (wr_clr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .sb_any    (sb_any)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset     = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_clr    = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int w, input logic [4:0] a, input logic [31:0] d, input logic clr);
        wr_en[w]             = 1'b1;
        wr_addr[w*c_AW +: c_AW] = a;
        wr_data[w*c_W +: c_W]   = d;
        wr_clr[w]            = clr;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        idle();
        set_rd(5'd5, 5'd0);
        #1;

        // 1: reset state, then write x5 and reset it away
        reset = 1'b1;
        tick();
        idle();
        #1;
        check("rst_data_x5", rd_data[31:0], 32'h0);
        check("rst_busy", {30'd0, rd_busy}, 32'h0);
        check("rst_sb_any", {31'd0, sb_any}, 32'h0);
        set_wr(0, 5'd5, 32'hDEAD, 1'b0);
        tick();
        idle();
        #1;
        check("x5_written", rd_data[31:0], 32'hDEAD);
        reset = 1'b1;
        tick();
        idle();
        #1;
        check("x5_after_rst", rd_data[31:0], 32'h0);

        // 2: x0 is hardwired and never busy
        set_rd(5'd0, 5'd0);
        set_wr(0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        #1;
        check("x0_bypass", rd_data[31:0], 32'h0);
        tick();
        idle();
        #1;
        check("x0_read", rd_data[63:32], 32'h0);
        check("x0_busy", {30'd0, rd_busy}, 32'h0);
        check("x0_sb_any", {31'd0, sb_any}, 32'h0);

        // 3: two writes to x7, higher port wins in bypass and in storage
        set_rd(5'd0, 5'd7);
        set_wr(0, 5'd7, 32'h11, 1'b0);
        set_wr(1, 5'd7, 32'h22, 1'b0);
        #1;
        check("x7_bypass_prio", rd_data[63:32], 32'h22);
        tick();
        idle();
        set_rd(5'd7, 5'd7);
        #1;
        check("x7_stored_p0", rd_data[31:0], 32'h22);
        check("x7_stored_p1", rd_data[63:32], 32'h22);

        // 4: issue x9, busy next cycle, retiring write unblocks same cycle
        set_rd(5'd9, 5'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        #1;
        check("x9_iss_same_cyc", {31'd0, rd_busy[0]}, 32'h0);
        tick();
        idle();
        #1;
        check("x9_busy", {31'd0, rd_busy[0]}, 32'h1);
        check("x9_sb_any", {31'd0, sb_any}, 32'h1);
        set_wr(1, 5'd9, 32'h55, 1'b1);
        #1;
        check("x9_clr_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x9_clr_data", rd_data[31:0], 32'h55);
        tick();
        idle();
        #1;
        check("x9_after_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("x9_after_sb_any", {31'd0, sb_any}, 32'h0);
        check("x9_after_data", rd_data[31:0], 32'h55);

        // early write without clear, then clear without enable
        set_rd(5'd10, 5'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd10;
        tick();
        idle();
        set_wr(0, 5'd10, 32'h66, 1'b0);
        tick();
        idle();
        #1;
        check("x10_early_busy", {31'd0, rd_busy[0]}, 32'h1);
        check("x10_early_data", rd_data[31:0], 32'h66);
        wr_clr[0]        = 1'b1;
        wr_addr[4:0]     = 5'd10;
        #1;
        check("x10_clr_noen", {31'd0, rd_busy[0]}, 32'h1);
        tick();
        idle();
        #1;
        check("x10_clr_noen_nxt", {31'd0, rd_busy[0]}, 32'h1);
        set_wr(0, 5'd10, 32'h77, 1'b1);
        tick();
        idle();
        #1;
        check("x10_retired", {31'd0, sb_any}, 32'h0);

        // 5: clear and set of x3 in the same cycle leaves it busy
        set_rd(5'd3, 5'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        tick();
        idle();
        #1;
        check("x3_busy", {31'd0, rd_busy[0]}, 32'h1);
        set_wr(0, 5'd3, 32'h33, 1'b1);
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        #1;
        check("x3_collide_same", {31'd0, rd_busy[0]}, 32'h0);
        tick();
        idle();
        #1;
        check("x3_collide_busy", {31'd0, rd_busy[0]}, 32'h1);
        check("x3_collide_data", rd_data[31:0], 32'h33);

        // 6: reset clears x4/x6 busy and beats a concurrent issue of x8
        iss_valid = 1'b1;
        iss_rd    = 5'd4;
        tick();
        iss_rd    = 5'd6;
        tick();
        idle();
        set_rd(5'd4, 5'd6);
        #1;
        check("x4x6_busy", {30'd0, rd_busy}, 32'h3);
        reset     = 1'b1;
        iss_valid = 1'b1;
        iss_rd    = 5'd8;
        set_wr(0, 5'd4, 32'h44, 1'b0);
        tick();
        idle();
        #1;
        check("rst_x4x6_busy", {30'd0, rd_busy}, 32'h0);
        check("rst_x4_data", rd_data[31:0], 32'h0);
        set_rd(5'd8, 5'd3);
        #1;
        check("rst_x8_x3_busy", {30'd0, rd_busy}, 32'h0);
        check("rst_sb_any_mid", {31'd0, sb_any}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule : tb_regfile_mp_scoreboard

`default_nettype wire
